// File: rtl/shifter_pkg.sv
// Shared types and constants for the multi-channel AXI4-Lite shifter slave.
package shifter_pkg;

  typedef enum logic [1:0] {
    MODE_LSL = 2'd0,
    MODE_LSR = 2'd1,
    MODE_ASR = 2'd2,
    MODE_ROR = 2'd3
  } shift_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } ch_state_e;

  // Word offsets (addr[3:2]) inside a channel's 16-byte window
  localparam logic [1:0] REG_DIN    = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_RESULT = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // Word offsets (addr[2]) inside the IRQ window at NUM_CH*16
  localparam logic REG_IRQ_EN   = 1'b0;
  localparam logic REG_IRQ_PEND = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/shifter_core.sv
// One iterative shifter channel: snapshots operands on start, shifts up to STEP
// bits per cycle, publishes RESULT and a one-cycle done pulse.
module shifter_core
  import shifter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STEP   = 1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic [7:0]        amt_i,
  input  shift_mode_e       mode_i,
  output logic              busy_o,
  output logic              done_pulse_o,
  output logic [DATA_W-1:0] result_o
);

  ch_state_e         state_q, state_d;
  shift_mode_e       mode_q;
  logic [DATA_W-1:0] data_q, result_q, ld_data, shifted;
  logic [7:0]        rem_q, ld_amt, step;
  logic              last;

  // Out-of-range amounts are folded here so the shift never runs past DATA_W-1 steps
  always_comb begin
    ld_data = din_i;
    ld_amt  = amt_i;
    if (mode_i == MODE_ROR) begin
      ld_amt = 8'(int'(amt_i) % DATA_W);
    end else if (int'(amt_i) >= DATA_W) begin
      ld_amt = 8'(DATA_W - 1);
      if (mode_i != MODE_ASR) ld_data = '0;
    end
  end

  assign step = (rem_q < 8'(STEP)) ? rem_q : 8'(STEP);
  assign last = (rem_q <= 8'(STEP));

  always_comb begin
    case (mode_q)
      MODE_LSL: shifted = data_q << step;
      MODE_LSR: shifted = data_q >> step;
      MODE_ASR: shifted = $unsigned($signed(data_q) >>> step);
      default:  shifted = (data_q >> step) | (data_q << (8'(DATA_W) - step));
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = (ld_amt == 8'd0) ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (last)    state_d = ST_DONE;
      default:               state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o       = (state_q == ST_SHIFT);
    done_pulse_o = (state_q == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      rem_q    <= '0;
      mode_q   <= MODE_LSL;
      result_q <= '0;
    end else if (state_q == ST_IDLE && start_i) begin
      data_q <= ld_data;
      rem_q  <= ld_amt;
      mode_q <= mode_i;
      if (ld_amt == 8'd0) result_q <= ld_data;
    end else if (state_q == ST_SHIFT) begin
      data_q <= shifted;
      rem_q  <= rem_q - step;
      if (last) result_q <= shifted;
    end
  end

  assign result_o = result_q;

endmodule

// File: rtl/axi_lite_shifter_mc.sv
// AXI4-Lite front end for NUM_CH shifter channels: handshakes, decode, register file.
// Optional interrupt block enabled by defining SHIFTER_IRQ_EN.
module axi_lite_shifter_mc
  import shifter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int STEP   = 1,
  parameter int ADDR_W = 8
)(
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ADDR_W-1:0] S_AXI_AWADDR,
  input  logic [2:0]        S_AXI_AWPROT,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [31:0]       S_AXI_WDATA,
  input  logic [3:0]        S_AXI_WSTRB,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [ADDR_W-1:0] S_AXI_ARADDR,
  input  logic [2:0]        S_AXI_ARPROT,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [31:0]       S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY
`ifdef SHIFTER_IRQ_EN
  ,output logic             irq
`endif
);

  localparam int CH_W = ADDR_W - 4;

  logic [NUM_CH-1:0][DATA_W-1:0] din_q, din_d, result;
  logic [NUM_CH-1:0][7:0]        amt_q, amt_d;
  logic [NUM_CH-1:0][1:0]        mode_q, mode_d;
  logic [NUM_CH-1:0]             start_q, start_d, done_q, done_d, done_w1c, busy, done_pulse;

  logic        wr_rdy_q, wr_rdy_d, wr_hs, bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d, wr_resp;
  logic        rvalid_q, rvalid_d, arready, ar_hs;
  logic [31:0] rdata_q, rdata_d, rd_word, ctrl_word;
  logic [1:0]  rresp_q, rresp_d, rd_resp;
  logic [CH_W-1:0] wr_ch, rd_ch;

`ifdef SHIFTER_IRQ_EN
  logic [NUM_CH-1:0] irq_en_q, irq_en_d, pend_q, pend_d, pend_w1c;
  logic              irq_q, irq_d;
`endif

  assign wr_ch = S_AXI_AWADDR[ADDR_W-1:4];
  assign rd_ch = S_AXI_ARADDR[ADDR_W-1:4];

  // Ready is a registered one-cycle pulse, so the transfer completes on the edge after it rises
  assign wr_hs    = wr_rdy_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign wr_rdy_d = S_AXI_AWVALID & S_AXI_WVALID & ~wr_rdy_q & ~bvalid_q;
  assign bvalid_d = wr_hs | (bvalid_q & ~S_AXI_BREADY);
  assign bresp_d  = wr_hs ? wr_resp : bresp_q;

  always_comb begin
    din_d     = din_q;
    amt_d     = amt_q;
    mode_d    = mode_q;
    start_d   = '0;
    done_w1c  = '0;
    ctrl_word = '0;
    wr_resp   = RESP_OKAY;
`ifdef SHIFTER_IRQ_EN
    irq_en_d  = irq_en_q;
    pend_w1c  = '0;
`endif
    if (wr_hs) begin
      wr_resp = RESP_SLVERR;
      for (int c = 0; c < NUM_CH; c++) begin
        if (int'(wr_ch) == c) begin
          wr_resp = RESP_OKAY;
          case (S_AXI_AWADDR[3:2])
            REG_DIN: din_d[c] = DATA_W'(strb_merge(32'(din_q[c]), S_AXI_WDATA, S_AXI_WSTRB));
            REG_CTRL: begin
              // A pending or running command rejects a restart and keeps CTRL intact
              if (S_AXI_WDATA[31] && S_AXI_WSTRB[3] && (busy[c] || start_q[c])) begin
                wr_resp = RESP_SLVERR;
              end else begin
                ctrl_word  = strb_merge({22'd0, mode_q[c], amt_q[c]}, S_AXI_WDATA, S_AXI_WSTRB);
                amt_d[c]   = ctrl_word[7:0];
                mode_d[c]  = ctrl_word[9:8];
                start_d[c] = S_AXI_WDATA[31] & S_AXI_WSTRB[3];
              end
            end
            REG_STATUS: done_w1c[c] = S_AXI_WDATA[1] & S_AXI_WSTRB[0];
            default: ;
          endcase
        end
      end
`ifdef SHIFTER_IRQ_EN
      if (int'(wr_ch) == NUM_CH && !S_AXI_AWADDR[3]) begin
        wr_resp = RESP_OKAY;
        if (S_AXI_AWADDR[2] == REG_IRQ_EN)
          irq_en_d = NUM_CH'(strb_merge(32'(irq_en_q), S_AXI_WDATA, S_AXI_WSTRB));
        else
          pend_w1c = S_AXI_WDATA[NUM_CH-1:0] & {NUM_CH{S_AXI_WSTRB[0]}};
      end
`endif
    end
  end

  assign done_d = (done_q & ~done_w1c) | done_pulse;

`ifdef SHIFTER_IRQ_EN
  assign pend_d = (pend_q & ~pend_w1c) | (done_d & ~done_q);
  assign irq_d  = |(irq_en_d & pend_d);
  assign irq    = irq_q;
`endif

  assign arready  = ~rvalid_q & ~ARESET;
  assign ar_hs    = S_AXI_ARVALID & arready;
  assign rvalid_d = ar_hs | (rvalid_q & ~S_AXI_RREADY);
  assign rdata_d  = ar_hs ? rd_word : rdata_q;
  assign rresp_d  = ar_hs ? rd_resp : rresp_q;

  always_comb begin
    rd_word = '0;
    rd_resp = RESP_SLVERR;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(rd_ch) == c) begin
        rd_resp = RESP_OKAY;
        case (S_AXI_ARADDR[3:2])
          REG_DIN:    rd_word = 32'(din_q[c]);
          REG_CTRL:   rd_word = {22'd0, mode_q[c], amt_q[c]};
          REG_RESULT: rd_word = 32'(result[c]);
          default:    rd_word = {30'd0, done_q[c], busy[c]};
        endcase
      end
    end
`ifdef SHIFTER_IRQ_EN
    if (int'(rd_ch) == NUM_CH && !S_AXI_ARADDR[3]) begin
      rd_resp = RESP_OKAY;
      rd_word = (S_AXI_ARADDR[2] == REG_IRQ_EN) ? 32'(irq_en_q) : 32'(pend_q);
    end
`endif
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      din_q    <= '0;
      amt_q    <= '0;
      mode_q   <= '0;
      start_q  <= '0;
      done_q   <= '0;
      wr_rdy_q <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
`ifdef SHIFTER_IRQ_EN
      irq_en_q <= '0;
      pend_q   <= '0;
      irq_q    <= 1'b0;
`endif
    end else begin
      din_q    <= din_d;
      amt_q    <= amt_d;
      mode_q   <= mode_d;
      start_q  <= start_d;
      done_q   <= done_d;
      wr_rdy_q <= wr_rdy_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
`ifdef SHIFTER_IRQ_EN
      irq_en_q <= irq_en_d;
      pend_q   <= pend_d;
      irq_q    <= irq_d;
`endif
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    shifter_core #(.DATA_W(DATA_W), .STEP(STEP)) u_core (
      .clk          (ACLK),
      .rst          (ARESET),
      .start_i      (start_q[c]),
      .din_i        (din_q[c]),
      .amt_i        (amt_q[c]),
      .mode_i       (shift_mode_e'(mode_q[c])),
      .busy_o       (busy[c]),
      .done_pulse_o (done_pulse[c]),
      .result_o     (result[c])
    );
  end

  assign S_AXI_AWREADY = wr_rdy_q;
  assign S_AXI_WREADY  = wr_rdy_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                       ctrl_word[31:10]};

endmodule

// File: tb/tb_axi_lite_shifter_mc.sv
// Directed bench for axi_lite_shifter_mc (defaults: 4 ch, 32-bit, STEP=1).
module tb_axi_lite_shifter_mc;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam int         TMO    = 50;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [7:0]  S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
  logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY;
  logic        S_AXI_ARVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RREADY;
`ifdef SHIFTER_IRQ_EN
  logic        irq;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 ACLK = ~ACLK;

  axi_lite_shifter_mc dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
`ifdef SHIFTER_IRQ_EN
    ,.irq(irq)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic axi_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [1:0] resp);
    int n;
    @(negedge ACLK);
    S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA  = d; S_AXI_WSTRB   = s; S_AXI_WVALID = 1'b1;
    S_AXI_BREADY = 1'b1;
    n = 0;
    while (!S_AXI_AWREADY && n < TMO) begin @(negedge ACLK); n++; end
    if (n == TMO) chk("wr_aw_timeout", n, 0);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    n = 0;
    while (!S_AXI_BVALID && n < TMO) begin @(negedge ACLK); n++; end
    if (n == TMO) chk("wr_b_timeout", n, 0);
    resp = S_AXI_BRESP;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_rd(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(negedge ACLK);
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    n = 0;
    while (!S_AXI_ARREADY && n < TMO) begin @(negedge ACLK); n++; end
    if (n == TMO) chk("rd_ar_timeout", n, 0);
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!S_AXI_RVALID && n < TMO) begin @(negedge ACLK); n++; end
    if (n == TMO) chk("rd_r_timeout", n, 0);
    d = S_AXI_RDATA; resp = S_AXI_RRESP;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] d, d4;
  logic [1:0]  r, r4;

  initial begin
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_awready", S_AXI_AWREADY, 0);
    chk("rst_arready", S_AXI_ARREADY, 0);
    chk("rst_bvalid",  S_AXI_BVALID, 0);
    chk("rst_rvalid",  S_AXI_RVALID, 0);
    chk("rst_rdata",   S_AXI_RDATA, 0);
`ifdef SHIFTER_IRQ_EN
    chk("rst_irq", irq, 0);
`endif
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("idle_arready", S_AXI_ARREADY, 1);
    axi_rd(8'h0C, d, r); chk("rst_status0", d, 0); chk("rst_status0_resp", r, OKAY);
    axi_rd(8'h04, d, r); chk("rst_ctrl0", d, 0);

    // 1: ch0 LSL 4 of 1
    axi_wr(8'h00, 32'h0000_0001, 4'hF, r); chk("t1_din_resp", r, OKAY);
    axi_wr(8'h04, 32'h8000_0004, 4'hF, r); chk("t1_ctrl_resp", r, OKAY);
    axi_rd(8'h0C, d, r); chk("t1_busy", d, 32'h1);
    repeat (10) @(posedge ACLK);
    axi_rd(8'h0C, d, r); chk("t1_done", d, 32'h2);
    axi_rd(8'h08, d, r); chk("t1_result", d, 32'h0000_0010);
    axi_rd(8'h04, d, r); chk("t1_ctrl_start_reads0", d, 32'h0000_0004);
    axi_wr(8'h08, 32'hFFFF_FFFF, 4'hF, r); chk("t1_ro_write_resp", r, OKAY);
    axi_rd(8'h08, d, r); chk("t1_ro_unchanged", d, 32'h0000_0010);
    axi_wr(8'h0C, 32'h0000_0002, 4'hF, r);
    axi_rd(8'h0C, d, r); chk("t1_done_w1c", d, 32'h0);

    // 2: ch1 ASR 31, ROR 36, LSR 40
    axi_wr(8'h10, 32'h8000_0000, 4'hF, r);
    axi_wr(8'h14, 32'h8000_021F, 4'hF, r);
    repeat (40) @(posedge ACLK);
    axi_rd(8'h18, d, r); chk("t2_asr31", d, 32'hFFFF_FFFF);
    axi_wr(8'h10, 32'h0000_0001, 4'hF, r);
    axi_wr(8'h14, 32'h8000_0324, 4'hF, r);
    repeat (10) @(posedge ACLK);
    axi_rd(8'h18, d, r); chk("t2_ror36", d, 32'h1000_0000);
    axi_wr(8'h10, 32'hFFFF_FFFF, 4'hF, r);
    axi_wr(8'h14, 32'h8000_0128, 4'hF, r);
    repeat (40) @(posedge ACLK);
    axi_rd(8'h18, d, r); chk("t2_lsr40", d, 32'h0);

    // 3: restart while busy on ch2
    axi_wr(8'h20, 32'h0000_00FF, 4'hF, r);
    axi_wr(8'h24, 32'h8000_0008, 4'hF, r);
    axi_wr(8'h24, 32'h8000_0101, 4'hF, r); chk("t3_busy_start_slverr", r, SLVERR);
    axi_wr(8'h20, 32'h0000_1234, 4'hF, r); chk("t3_din_busy_resp", r, OKAY);
    repeat (20) @(posedge ACLK);
    axi_rd(8'h28, d, r); chk("t3_result_first_cmd", d, 32'h0000_FF00);
    axi_rd(8'h24, d, r); chk("t3_ctrl_kept", d, 32'h0000_0008);
    axi_rd(8'h20, d, r); chk("t3_din_updated", d, 32'h0000_1234);

    // byte strobes and amt_eff = 0 on ch3
    axi_wr(8'h30, 32'hFFFF_FFFF, 4'hF, r);
    axi_wr(8'h30, 32'h1122_3344, 4'h5, r);
    axi_rd(8'h30, d, r); chk("strb_din", d, 32'hFF22_FF44);
    axi_wr(8'h30, 32'hDEAD_BEEF, 4'hF, r);
    axi_wr(8'h34, 32'h8000_0320, 4'hF, r);
    repeat (4) @(posedge ACLK);
    axi_rd(8'h38, d, r); chk("ror32_passthru", d, 32'hDEAD_BEEF);
    axi_rd(8'h3C, d, r); chk("ror32_done", d, 32'h2);

    // 4: W leads AW by 3 cycles, BREADY held low, concurrent read of ch0 RESULT
    fork
      begin : t4_wr
        int n, early, hold;
        @(negedge ACLK);
        S_AXI_WDATA = 32'h0000_00A5; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
        early = 0;
        repeat (3) begin @(negedge ACLK); if (S_AXI_AWREADY || S_AXI_WREADY) early++; end
        chk("t4_no_early_ready", early, 0);
        S_AXI_AWADDR = 8'h00; S_AXI_AWVALID = 1'b1;
        n = 0;
        while (!S_AXI_AWREADY && n < TMO) begin @(negedge ACLK); n++; end
        if (n == TMO) chk("t4_aw_timeout", n, 0);
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        hold = 0;
        repeat (5) begin @(negedge ACLK); if (S_AXI_BVALID) hold++; end
        chk("t4_bvalid_hold", hold, 5);
        chk("t4_bresp", S_AXI_BRESP, OKAY);
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        @(negedge ACLK);
        chk("t4_bvalid_clear", S_AXI_BVALID, 0);
      end
      begin : t4_rd
        axi_rd(8'h08, d4, r4);
        chk("t4_conc_read", d4, 32'h0000_0010);
        chk("t4_conc_read_resp", r4, OKAY);
      end
    join
    axi_rd(8'h00, d, r); chk("t4_din_written", d, 32'h0000_00A5);

    // unmapped accesses
    axi_rd(8'hFC, d, r); chk("unmapped_rd_resp", r, SLVERR); chk("unmapped_rd_data", d, 0);
    axi_wr(8'h50, 32'h1234_5678, 4'hF, r); chk("unmapped_wr_resp", r, SLVERR);
`ifndef SHIFTER_IRQ_EN
    axi_rd(8'h40, d, r); chk("irq_off_unmapped", r, SLVERR);
`endif

    // 5: reset mid-shift
    axi_wr(8'h00, 32'h0000_000F, 4'hF, r);
    axi_wr(8'h04, 32'h8000_0014, 4'hF, r);
    axi_rd(8'h0C, d, r); chk("t5_busy_before_rst", d, 32'h1);
    @(negedge ACLK); ARESET = 1'b1;
    @(negedge ACLK);
    chk("t5_rvalid_in_rst", S_AXI_RVALID, 0);
    ARESET = 1'b0;
    axi_rd(8'h0C, d, r); chk("t5_status_after_rst", d, 0);
    axi_rd(8'h08, d, r); chk("t5_result_after_rst", d, 0);
    repeat (30) @(posedge ACLK);
    axi_rd(8'h0C, d, r); chk("t5_no_late_done", d, 0);

`ifdef SHIFTER_IRQ_EN
    // 6: interrupt on ch0 completion
    axi_wr(8'h40, 32'h0000_0001, 4'hF, r); chk("t6_irq_en_resp", r, OKAY);
    axi_wr(8'h00, 32'h0000_0001, 4'hF, r);
    axi_wr(8'h04, 32'h8000_0001, 4'hF, r);
    repeat (8) @(posedge ACLK);
    @(negedge ACLK); chk("t6_irq_set", irq, 1);
    axi_rd(8'h44, d, r); chk("t6_pend", d, 32'h1);
    axi_wr(8'h44, 32'h0000_0001, 4'hF, r);
    @(negedge ACLK); chk("t6_irq_clear", irq, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
